ppu_line_sink: RTL and testbench
================================

Name: ppu_line_sink

Overview:
- Downstream stage of the PPU. Consumes the PPU's pixel stream (disp_on, hsync, vsync, px_out, px) and assembles complete lines in a double-buffered line store.
- Maps each 2-bit shade to RGB565.
- Streams each committed line to the display controller over a valid/ready interface, with start-of-frame and end-of-line markers.
- Decouples the PPU's fixed 1-pixel-per-clk burst from a slower or stalling consumer.

Parameters:
- WIDTH, 160, pixels per line
- HEIGHT, 144, visible lines per frame
- SHADE0, 16'hFFFF, RGB565 for shade 0
- SHADE1, 16'hAD55, RGB565 for shade 1
- SHADE2, 16'h52AA, RGB565 for shade 2
- SHADE3, 16'h0000, RGB565 for shade 3

Ports:
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- disp_on  in  1  PPU enabled; low = flush
- hsync  in  1  one-cycle line-start strobe from PPU
- vsync  in  1  one-cycle frame-start strobe (coincident with hsync)
- px_out  in  1  px valid this cycle
- px  in  2  pixel shade
- out_data  out  16  RGB565 pixel
- out_y  out  8  line number of out_data (0..HEIGHT-1)
- out_sof  out  1  first pixel of line 0
- out_eol  out  1  last pixel of a line
- out_valid  out  1  out_* valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- overrun  out  1  one-cycle pulse: line dropped

Behaviour:
- Reset, and any cycle with disp_on=0: all outputs 0.
  - Both banks empty; wr_bank=rd_bank=0; wr_x=0; wr_y=0; write mode IDLE; read state IDLE.
  - disp_on low mid-line or mid-stream aborts immediately. A partial output line is not completed.
- Write side, modes IDLE / FILL / DROP:
  - hsync:
    - wr_x := 0.
    - If vsync, wr_y := 0.
    - If bank[wr_bank] is empty, mode := FILL.
    - Otherwise mode := DROP and overrun pulses on the next cycle.
    - A partially filled line (0 < wr_x < WIDTH) interrupted by hsync is discarded silently.
  - px_out in FILL: bank[wr_bank][wr_x] := px; wr_x += 1.
  - px_out on the pixel with wr_x = WIDTH-1 commits the line:
    - bank full := 1; line tag := wr_y.
    - wr_bank toggles; wr_y += 1.
    - mode := IDLE.
  - px_out in IDLE or DROP: ignored. DROP still increments wr_y at the hsync that follows, so line numbering stays aligned to LY.
  - px_out without a preceding hsync since the flush: ignored (mode is IDLE).
  - wr_y saturates at HEIGHT-1; it never wraps on its own.
- Read side, states IDLE / STREAM:
  - IDLE → STREAM when bank[rd_bank] is full. rd_x := 0.
  - out_valid rises exactly 2 clk after the commit edge: 1 cycle for the full flag, 1 cycle for the registered memory read.
  - The output register holds out_data, out_y, out_sof and out_eol stable while out_valid && !out_ready.
  - On acceptance, the next pixel is presented the following cycle. Throughput is 1 pixel/clk with out_ready held high (prefetch read, no bubble).
  - out_sof = (rd_x==0 && tag==0). out_eol = (rd_x==WIDTH-1).
  - Acceptance of the eol pixel:
    - bank[rd_bank] full := 0; rd_bank toggles.
    - If the other bank is already full, stay in STREAM with no bubble. Otherwise go to IDLE; out_valid drops the next cycle.
- Same-cycle events:
  - A commit and an eol release on the same edge are both honoured.
  - An hsync in that same cycle sees the released bank as empty. The empty test uses the post-release value.
- Arithmetic: wr_x and rd_x are 8 bits. The shade→RGB565 mapping is a 4-entry combinational mux on the registered read.

Decomposition:
- Package ppu_sink_pkg holds:
  - default SHADE0..3 RGB565 constants
  - write-mode encoding: IDLE=0, FILL=1, DROP=2
  - read-state encoding: IDLE=0, STREAM=1
- One sub-module, ppu_line_bank: 2×WIDTH×2-bit simple dual-port store.
  - One write port {bank, x, px, we}.
  - One registered read port {bank, x} → 2-bit shade, 1-cycle latency.
  - Maps to block RAM.
- Control, flags and palette mapping stay in ppu_line_sink.

Test Plan:
- Full frame, out_ready=1: send vsync+hsync, then 160 px_out of pattern x%4 on each of 144 lines. Expected:
  - 144×160 beats, data cycling FFFF,AD55,52AA,0000.
  - out_sof on beat 0 only; out_eol every 160th beat; out_y 0..143.
  - overrun never asserted.
- Latency: commit a line, then check out_valid rises exactly 2 clk after the 160th px_out edge. Expected: out_y=0, out_sof=1.
- Backpressure: out_ready=0 for 3 lines. Expected:
  - lines 0 and 1 are buffered; line 2 gets an overrun pulse 1 clk after its hsync.
  - After releasing out_ready: lines 0, 1, then 3 stream. out_y=3 for the third streamed line; data stays stable while stalled.
- Stall toggling: out_ready alternates 1/0. Expected: each pixel is accepted exactly once and no data changes while out_valid && !out_ready.
- Partial line and flush: send hsync, 80 px_out, then hsync. Expected: no output for that line. Then disp_on=0 mid-stream. Expected: out_valid=0 next cycle, both banks empty, nothing replayed after disp_on returns.
- Reset during STREAM: synchronous reset pulse. Expected: all outputs 0 the next cycle and the first post-reset line streams with out_y=0.

Source files
------------

// File: rtl/ppu_sink_pkg.sv
// Shared constants and state encodings for the PPU line sink.
package ppu_sink_pkg;

  localparam logic [15:0] DEF_SHADE0 = 16'hFFFF;
  localparam logic [15:0] DEF_SHADE1 = 16'hAD55;
  localparam logic [15:0] DEF_SHADE2 = 16'h52AA;
  localparam logic [15:0] DEF_SHADE3 = 16'h0000;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wrMode_e;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rdState_e;

endpackage

// File: rtl/ppu_line_bank.sv
// Two-line shade store: one write port, one registered read port (block RAM style).
module ppu_line_bank
  import ppu_sink_pkg::*;
#(
  parameter int WIDTH = 160
) (
  input  logic       i_clk,
  input  logic       i_we,
  input  logic       i_wrBank,
  input  logic [7:0] i_wrX,
  input  logic [1:0] i_wrPx,
  input  logic       i_rdBank,
  input  logic [7:0] i_rdX,
  output logic [1:0] o_rdPx
);

  logic [1:0] r_mem [2][WIDTH];

  // No reset: contents are only ever read from a bank flagged full.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wrBank][i_wrX] <= i_wrPx;
    o_rdPx <= r_mem[i_rdBank][i_rdX];
  end

endmodule

// File: rtl/ppu_line_sink.sv
// Collects PPU pixel bursts into a double-buffered line store and streams
// committed lines as RGB565 over valid/ready with SOF/EOL markers.
module ppu_line_sink
  import ppu_sink_pkg::*;
#(
  parameter int          WIDTH  = 160,
  parameter int          HEIGHT = 144,
  parameter logic [15:0] SHADE0 = DEF_SHADE0,
  parameter logic [15:0] SHADE1 = DEF_SHADE1,
  parameter logic [15:0] SHADE2 = DEF_SHADE2,
  parameter logic [15:0] SHADE3 = DEF_SHADE3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_on,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        px_out,
  input  logic [1:0]  px,
  output logic [15:0] out_data,
  output logic [7:0]  out_y,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  localparam logic [7:0] LAST_X = 8'(WIDTH - 1);
  localparam logic [7:0] LAST_Y = 8'(HEIGHT - 1);

  logic [1:0] r_full;
  logic [7:0] r_tag [2];
  logic       r_wrBank;
  logic [7:0] r_wrX;
  logic [7:0] r_wrY;
  wrMode_e    r_wrMode;
  logic       r_rdBank;
  logic [7:0] r_rdX;
  rdState_e   r_rdState;
  logic       r_outValid;
  logic [7:0] r_outY;
  logic       r_outSof;
  logic       r_outEol;
  logic       r_overrun;

  logic       w_we;
  logic       w_commit;
  logic       w_accept;
  logic       w_release;
  logic       w_chain;
  logic [1:0] w_fullNext;
  logic       w_load;
  logic       w_ldBank;
  logic [7:0] w_ldX;
  logic [1:0] w_shade;

  assign w_we      = disp_on && !hsync && px_out && (r_wrMode == WR_FILL);
  assign w_commit  = w_we && (r_wrX == LAST_X);
  assign w_accept  = r_outValid && out_ready;
  assign w_release = w_accept && r_outEol;
  assign w_chain   = w_release && r_full[~r_rdBank];

  // Flags after this edge; hsync tests emptiness against the post-release value.
  always_comb begin
    w_fullNext = r_full;
    if (w_release) w_fullNext[r_rdBank] = 1'b0;
    if (w_commit)  w_fullNext[r_wrBank] = 1'b1;
  end

  // Read address doubles as the prefetch: it points at the pixel the output
  // register will hold after this edge, so a stall simply re-reads it.
  always_comb begin
    w_load   = 1'b0;
    w_ldBank = r_rdBank;
    w_ldX    = r_rdX;
    if (r_rdState == RD_STREAM) begin
      if (!r_outValid) begin
        w_load = 1'b1;
      end else if (w_accept) begin
        if (!r_outEol) begin
          w_load = 1'b1;
          w_ldX  = r_rdX + 8'd1;
        end else if (w_chain) begin
          w_load   = 1'b1;
          w_ldBank = ~r_rdBank;
          w_ldX    = 8'd0;
        end
      end
    end
  end

  ppu_line_bank #(.WIDTH(WIDTH)) u_bank (
    .i_clk    (clk),
    .i_we     (w_we),
    .i_wrBank (r_wrBank),
    .i_wrX    (r_wrX),
    .i_wrPx   (px),
    .i_rdBank (w_ldBank),
    .i_rdX    (w_ldX),
    .o_rdPx   (w_shade)
  );

  always_ff @(posedge clk) begin
    if (reset || !disp_on) r_full <= '0;
    else                   r_full <= w_fullNext;
  end

  always_ff @(posedge clk) begin
    if (reset || !disp_on) begin
      r_wrBank  <= 1'b0;
      r_wrX     <= '0;
      r_wrY     <= '0;
      r_wrMode  <= WR_IDLE;
      r_tag[0]  <= '0;
      r_tag[1]  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (hsync) begin
        r_wrX <= '0;
        if (vsync) r_wrY <= '0;
        else if (r_wrMode == WR_DROP && r_wrY != LAST_Y) r_wrY <= r_wrY + 8'd1;
        if (!w_fullNext[r_wrBank]) begin
          r_wrMode <= WR_FILL;
        end else begin
          r_wrMode  <= WR_DROP;
          r_overrun <= 1'b1;
        end
      end else if (w_commit) begin
        r_tag[r_wrBank] <= r_wrY;
        r_wrBank        <= ~r_wrBank;
        r_wrX           <= '0;
        r_wrMode        <= WR_IDLE;
        if (r_wrY != LAST_Y) r_wrY <= r_wrY + 8'd1;
      end else if (w_we) begin
        r_wrX <= r_wrX + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !disp_on) begin
      r_rdState  <= RD_IDLE;
      r_rdBank   <= 1'b0;
      r_rdX      <= '0;
      r_outValid <= 1'b0;
      r_outY     <= '0;
      r_outSof   <= 1'b0;
      r_outEol   <= 1'b0;
    end else begin
      case (r_rdState)
        RD_IDLE: begin
          if (r_full[r_rdBank]) begin
            r_rdState <= RD_STREAM;
            r_rdX     <= '0;
          end
        end
        RD_STREAM: begin
          if (w_release) begin
            r_rdBank <= ~r_rdBank;
            if (!w_chain) r_rdState <= RD_IDLE;
          end
        end
        default: r_rdState <= RD_IDLE;
      endcase
      if (w_load) begin
        r_rdX      <= w_ldX;
        r_outValid <= 1'b1;
        r_outY     <= r_tag[w_ldBank];
        r_outSof   <= (w_ldX == 8'd0) && (r_tag[w_ldBank] == 8'd0);
        r_outEol   <= (w_ldX == LAST_X);
      end else if (w_release) begin
        r_outValid <= 1'b0;
        r_outY     <= '0;
        r_outSof   <= 1'b0;
        r_outEol   <= 1'b0;
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (r_outValid) begin
      case (w_shade)
        2'd0:    out_data = SHADE0;
        2'd1:    out_data = SHADE1;
        2'd2:    out_data = SHADE2;
        default: out_data = SHADE3;
      endcase
    end
  end

  assign out_valid = r_outValid;
  assign out_y     = r_outY;
  assign out_sof   = r_outSof;
  assign out_eol   = r_outEol;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_ppu_line_sink.sv
// Self-checking bench for ppu_line_sink: line-level reference model with a
// queue of expected output beats, consumer monitor and directed scenarios.
module tb_ppu_line_sink;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        disp_on = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic        px_out = 1'b0;
  logic [1:0]  px = 2'd0;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [7:0]  out_y;
  logic        out_sof;
  logic        out_eol;
  logic        out_valid;
  logic        overrun;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  y;
    logic        sof;
    logic        eol;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  beat_t       expQ[$];
  logic [15:0] palette [4] = '{16'hFFFF, 16'hAD55, 16'h52AA, 16'h0000};
  int          mY = 0;
  bit          mPendingDrop = 1'b0;
  int          mDrops = 0;
  int          beatCount = 0;
  int          ovCount = 0;
  int          readyMode = 0;

  always #5 clk = ~clk;

  ppu_line_sink dut (
    .clk       (clk),
    .reset     (reset),
    .disp_on   (disp_on),
    .hsync     (hsync),
    .vsync     (vsync),
    .px_out    (px_out),
    .px        (px),
    .out_data  (out_data),
    .out_y     (out_y),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic modelClear();
    expQ.delete();
    mY = 0;
    mPendingDrop = 1'b0;
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_data"}, 32'(out_data), 32'd0);
    checkOutput({tag, "_y"}, 32'(out_y), 32'd0);
    checkOutput({tag, "_sof"}, 32'(out_sof), 32'd0);
    checkOutput({tag, "_eol"}, 32'(out_eol), 32'd0);
    checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  // One PPU line: hsync cycle then nPx pixels; pattern 0 = x%4, else random.
  task automatic applyStimulus(input bit vs, input int nPx, input int pat, input bit expAccept);
    logic [1:0] pxv [160];
    beat_t      b;
    hsync = 1'b1;
    vsync = vs;
    px_out = 1'b0;
    tick();
    hsync = 1'b0;
    vsync = 1'b0;
    checkOutput("overrun_after_hsync", 32'(overrun), 32'(!expAccept));
    if (vs) mY = 0;
    else if (mPendingDrop) mY = (mY < 143) ? mY + 1 : 143;
    mPendingDrop = !expAccept;
    if (!expAccept) mDrops++;
    for (int x = 0; x < nPx; x++) begin
      pxv[x] = (pat == 0) ? 2'(x % 4) : 2'($urandom_range(0, 3));
      px_out = 1'b1;
      px = pxv[x];
      tick();
    end
    px_out = 1'b0;
    px = 2'd0;
    if (expAccept && nPx == 160) begin
      for (int x = 0; x < 160; x++) begin
        b.data = palette[pxv[x]];
        b.y    = 8'(mY);
        b.sof  = (x == 0) && (mY == 0);
        b.eol  = (x == 159);
        expQ.push_back(b);
      end
      mY = (mY < 143) ? mY + 1 : 143;
    end
  endtask

  task automatic waitDrain(input int budget, input int leave);
    int c = 0;
    while (expQ.size() > leave && c < budget) begin
      tick();
      c++;
    end
    checkOutput("drain_within_budget", 32'(expQ.size() <= leave), 32'd1);
  endtask

  // Consumer side: 0 = stalled, 1 = always ready, 2 = alternating, 3 = random.
  initial forever begin
    @(posedge clk);
    #1;
    case (readyMode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      2:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: scoreboard accepted beats and hold-while-stalled behaviour.
  initial begin
    logic        prevStall;
    logic        prevFlush;
    logic [15:0] pData;
    logic [7:0]  pY;
    logic [1:0]  pFlags;
    beat_t       b;
    prevStall = 1'b0;
    prevFlush = 1'b1;
    pData = '0;
    pY = '0;
    pFlags = '0;
    forever begin
      @(negedge clk);
      if (prevStall && !prevFlush) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_data", 32'(out_data), 32'(pData));
        checkOutput("stall_y", 32'(out_y), 32'(pY));
        checkOutput("stall_sof_eol", 32'({out_sof, out_eol}), 32'(pFlags));
      end
      if (out_valid && out_ready) begin
        beatCount++;
        checkOutput("beat_expected", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          b = expQ.pop_front();
          checkOutput("beat_data", 32'(out_data), 32'(b.data));
          checkOutput("beat_y", 32'(out_y), 32'(b.y));
          checkOutput("beat_sof", 32'(out_sof), 32'(b.sof));
          checkOutput("beat_eol", 32'(out_eol), 32'(b.eol));
        end
      end
      if (overrun) ovCount++;
      prevStall = out_valid && !out_ready;
      prevFlush = reset || !disp_on;
      pData = out_data;
      pY = out_y;
      pFlags = {out_sof, out_eol};
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int b0;
    int ov0;

    // Reset state
    reset = 1'b1;
    disp_on = 1'b1;
    idle(2);
    checkZero("reset");
    reset = 1'b0;
    modelClear();
    idle(2);

    // Commit-to-valid latency
    readyMode = 1;
    applyStimulus(1'b1, 160, 1, 1'b1);
    checkOutput("lat_edge0_valid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("lat_edge1_valid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("lat_edge2_valid", 32'(out_valid), 32'd1);
    checkOutput("lat_edge2_y", 32'(out_y), 32'd0);
    checkOutput("lat_edge2_sof", 32'(out_sof), 32'd1);
    waitDrain(400, 0);

    // Full frame, consumer always ready
    b0 = beatCount;
    ov0 = ovCount;
    for (int l = 0; l < 144; l++) begin
      applyStimulus(l == 0, 160, 0, 1'b1);
      idle(4);
    end
    waitDrain(400, 0);
    checkOutput("frame_beats", 32'(beatCount - b0), 32'd23040);
    checkOutput("frame_overruns", 32'(ovCount - ov0), 32'd0);

    // Backpressure: two lines buffered, third dropped
    reset = 1'b1;
    tick();
    reset = 1'b0;
    modelClear();
    readyMode = 0;
    idle(2);
    applyStimulus(1'b1, 160, 1, 1'b1);
    idle(2);
    applyStimulus(1'b0, 160, 1, 1'b1);
    idle(2);
    applyStimulus(1'b0, 160, 1, 1'b0);
    idle(2);
    checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_hold_y", 32'(out_y), 32'd0);
    checkOutput("bp_hold_sof", 32'(out_sof), 32'd1);
    checkOutput("bp_hold_data", 32'(out_data), 32'(expQ[0].data));
    readyMode = 1;
    waitDrain(400, 160);
    applyStimulus(1'b0, 160, 1, 1'b1);
    waitDrain(800, 0);

    // Stall toggling, then random readiness
    readyMode = 2;
    for (int l = 0; l < 2; l++) begin
      applyStimulus(l == 0, 160, 1, 1'b1);
      waitDrain(1000, 0);
    end
    readyMode = 3;
    for (int l = 0; l < 3; l++) begin
      applyStimulus(1'b0, 160, 1, 1'b1);
      idle(int'($urandom_range(0, 6)));
      waitDrain(2000, 0);
    end

    // Partial line is discarded, then flush mid-stream
    readyMode = 0;
    applyStimulus(1'b1, 160, 1, 1'b1);
    idle(2);
    applyStimulus(1'b0, 80, 1, 1'b1);
    applyStimulus(1'b0, 160, 1, 1'b1);
    readyMode = 1;
    waitDrain(800, 0);
    readyMode = 0;
    applyStimulus(1'b1, 160, 1, 1'b1);
    applyStimulus(1'b0, 160, 1, 1'b1);
    readyMode = 1;
    idle(40);
    disp_on = 1'b0;
    tick();
    checkZero("flush");
    modelClear();
    b0 = beatCount;
    idle(5);
    disp_on = 1'b1;
    idle(400);
    checkOutput("flush_no_replay", 32'(beatCount - b0), 32'd0);
    readyMode = 0;
    applyStimulus(1'b1, 160, 1, 1'b1);
    applyStimulus(1'b0, 160, 1, 1'b1);
    applyStimulus(1'b0, 160, 1, 1'b0);
    readyMode = 1;
    waitDrain(800, 0);

    // Reset while streaming
    applyStimulus(1'b1, 160, 1, 1'b1);
    idle(50);
    reset = 1'b1;
    tick();
    checkZero("rst_stream");
    reset = 1'b0;
    modelClear();
    idle(3);
    applyStimulus(1'b0, 160, 1, 1'b1);
    tick();
    tick();
    checkOutput("post_reset_y", 32'(out_y), 32'd0);
    checkOutput("post_reset_sof", 32'(out_sof), 32'd1);
    waitDrain(400, 0);

    idle(5);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("overrun_count", 32'(ovCount), 32'(mDrops));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
